// File: rtl/conv3x3_engine_if.sv
// Control, configuration and window/pixel bundle between the 3x3 convolution
// engine (slave) and the pixel source / configuration master.
interface conv3x3_engine_if;
    logic            i_start;
    logic            i_cfg_we;
    logic [3:0]      i_cfg_addr;
    logic [7:0]      i_cfg_data;
    logic            i_win_valid;
    logic [8:0][7:0] i_pixel;      // [0] = pixel_1 (top-left), row-major to [8] = pixel_9
    logic            o_rd;
    logic            o_busy;
    logic            o_out_valid;
    logic [7:0]      o_pixelw;
    logic            o_done;

    modport master (
        output i_start, i_cfg_we, i_cfg_addr, i_cfg_data, i_win_valid, i_pixel,
        input  o_rd, o_busy, o_out_valid, o_pixelw, o_done
    );

    modport slave (
        input  i_start, i_cfg_we, i_cfg_addr, i_cfg_data, i_win_valid, i_pixel,
        output o_rd, o_busy, o_out_valid, o_pixelw, o_done
    );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: frame sequencer issuing window reads, three-stage
// multiply / row-sum / total-shift-saturate pipeline, programmable signed kernel.
module conv3x3_engine #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    conv3x3_engine_if.slave   bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NPIX - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NPIX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      r_rd_cnt;
    logic [CW-1:0]      r_win_cnt;
    logic [CW-1:0]      r_out_cnt;
    logic               r_rd;
    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic [7:0]         r_pixelw;
    logic signed [7:0]  r_coef [9];
    logic signed [16:0] r_prod [9];
    logic signed [18:0] r_row  [3];
    logic               r_v1;
    logic               r_v2;
    logic               w_accept;
    logic               w_out_full;
    logic signed [20:0] w_total;
    logic signed [20:0] w_shift;
    logic [7:0]         w_sat;

    assign bus.o_rd        = r_rd;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_pixelw    = r_pixelw;

    // Windows beyond one frame's worth are dropped before entering the pipeline
    assign w_accept   = bus.i_win_valid && ((r_state == RUN) || (r_state == DRAIN)) &&
                        (r_win_cnt != CNT_FULL);
    // Includes the pulse leaving stage 3 this cycle so done follows the last output directly
    assign w_out_full = (r_out_cnt == CNT_FULL) || (r_out_valid && (r_out_cnt == CNT_LAST));

    // Next-state logic of the frame sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.i_start) w_state_nxt = RUN;
                else             w_state_nxt = IDLE;
            end
            RUN: begin
                if (r_rd_cnt == CNT_LAST) w_state_nxt = DRAIN;
                else                      w_state_nxt = RUN;
            end
            DRAIN: begin
                if (w_out_full) w_state_nxt = DONE;
                else            w_state_nxt = DRAIN;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, registered status outputs and frame counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rd      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_cnt  <= '0;
            r_win_cnt <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rd    <= (w_state_nxt == RUN);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
            if ((r_state == IDLE) && bus.i_start) begin
                r_rd_cnt  <= '0;
                r_win_cnt <= '0;
                r_out_cnt <= '0;
            end else begin
                if (r_state == RUN) r_rd_cnt  <= r_rd_cnt + CW'(1'b1);
                if (w_accept)       r_win_cnt <= r_win_cnt + CW'(1'b1);
                if (r_out_valid)    r_out_cnt <= r_out_cnt + CW'(1'b1);
            end
        end
    end

    // Kernel coefficients: identity on reset, writable only while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_coef[i] <= 8'sd0;
            r_coef[4] <= 8'd1 << SHIFT;
        end else if (bus.i_cfg_we && (r_state == IDLE) && (bus.i_cfg_addr <= 4'd8)) begin
            r_coef[bus.i_cfg_addr] <= bus.i_cfg_data;
        end
    end

    // Stage 3 combinational part: total, arithmetic shift and clamp to 0..255
    always_comb begin
        w_total = 21'(r_row[0]) + 21'(r_row[1]) + 21'(r_row[2]);
        w_shift = w_total >>> SHIFT;
        if (w_shift < 21'sd0) begin
            w_sat = 8'd0;
        end else if (w_shift > 21'sd255) begin
            w_sat = 8'd255;
        end else begin
            w_sat = w_shift[7:0];
        end
    end

    // Three-stage datapath with per-stage valid bits; pixelw holds between outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_pixelw    <= 8'd0;
            for (int i = 0; i < 9; i++) r_prod[i] <= 17'sd0;
            for (int r = 0; r < 3; r++) r_row[r]  <= 19'sd0;
        end else begin
            r_v1        <= w_accept;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            if (w_accept) begin
                for (int i = 0; i < 9; i++)
                    r_prod[i] <= 17'(r_coef[i]) * 17'($signed({1'b0, bus.i_pixel[i]}));
            end
            if (r_v1) begin
                for (int r = 0; r < 3; r++)
                    r_row[r] <= 19'(r_prod[3*r]) + 19'(r_prod[3*r+1]) + 19'(r_prod[3*r+2]);
            end
            if (r_v2) r_pixelw <= w_sat;
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: random windows and kernels scored
// against an integer convolution model with cycle-exact output timing.
module tb_conv3x3_engine;
    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int SHIFT = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv3x3_engine_if bus();
    conv3x3_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int k_m[9];
    int pix_m[9];
    int exp_pix[$];
    int exp_cyc[$];
    int obs_pix[$];
    int obs_cyc[$];
    int rd_cnt, rd_first, rd_last, done_cnt, done_cyc;
    logic post_busy, post_rd;
    logic ab_busy, ab_ov, ab_rd;

    // Reference: plain signed dot product, arithmetic shift, clamp
    function automatic int ref_pixel();
        int s = 0;
        for (int i = 0; i < 9; i++) s += k_m[i] * pix_m[i];
        s = s >>> SHIFT;
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic set_identity();
        for (int i = 0; i < 9; i++) k_m[i] = 0;
        k_m[4] = 16;
    endtask

    task automatic clear_obs();
        obs_pix.delete(); obs_cyc.delete();
        rd_cnt = 0; rd_first = -1; rd_last = -1; done_cnt = 0; done_cyc = -1;
    endtask

    // Advance one clock and record what the outputs show in the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_out_valid === 1'b1) begin
            obs_pix.push_back(int'(bus.o_pixelw));
            obs_cyc.push_back(cyc);
        end
        if (bus.o_rd === 1'b1) begin
            if (rd_cnt == 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
        end
        if (bus.o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // mode 0 random, 1 centre 37, 2 all 255, 3 centre 200
    task automatic drive_window(input int mode);
        for (int i = 0; i < 9; i++) begin
            case (mode)
                1:       pix_m[i] = (i == 4) ? 37 : 0;
                2:       pix_m[i] = 255;
                3:       pix_m[i] = (i == 4) ? 200 : 0;
                default: pix_m[i] = int'($urandom_range(0, 255));
            endcase
            bus.i_pixel[i] = 8'(pix_m[i]);
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_addr = 4'(addr);
        bus.i_cfg_data = 8'(val);
        tick();
        bus.i_cfg_we   = 1'b0;
        if (addr <= 8) k_m[addr] = val;
    endtask

    // One frame with win_valid = rd delayed by a cycle; optional extra windows,
    // mid-RUN start/cfg injection and a reset after abort_at outputs
    task automatic run_frame(input int first_mode, input int extra, input bit inject, input int abort_at);
        int   acc = 0;
        int   extra_left = extra;
        int   inj_cyc;
        logic prev_rd = 1'b0;
        logic wv;
        clear_obs();
        exp_pix.delete(); exp_cyc.delete();
        post_busy = 1'bx; post_rd = 1'bx;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        inj_cyc = cyc + 100;
        for (int c = 0; c < NPIX + 64; c++) begin
            bus.i_start  = 1'b0;
            bus.i_cfg_we = 1'b0;
            wv = prev_rd;
            if (!prev_rd && acc >= NPIX && extra_left > 0) begin
                wv = 1'b1;
                extra_left--;
            end
            if (wv) begin
                drive_window(acc == 0 ? first_mode : 0);
                if (acc < NPIX) begin
                    exp_pix.push_back(ref_pixel());
                    exp_cyc.push_back(cyc + 3);
                    acc++;
                end
            end
            bus.i_win_valid = wv;
            if (inject && cyc == inj_cyc) begin
                bus.i_start    = 1'b1;
                bus.i_cfg_we   = 1'b1;
                bus.i_cfg_addr = 4'd4;
                bus.i_cfg_data = 8'd0;
            end
            prev_rd = bus.o_rd;
            tick();
            if (abort_at > 0 && obs_pix.size() == abort_at) begin
                rst_n = 1'b0;
                bus.i_win_valid = 1'b0;
                bus.i_start = 1'b0;
                bus.i_cfg_we = 1'b0;
                tick();
                ab_busy = bus.o_busy; ab_ov = bus.o_out_valid; ab_rd = bus.o_rd;
                rst_n = 1'b1;
                for (int j = 0; j < 20; j++) tick();
                break;
            end
            if (done_cnt > 0) break;
        end
        bus.i_win_valid = 1'b0;
        bus.i_start = 1'b0;
        bus.i_cfg_we = 1'b0;
        if (done_cnt > 0) begin
            tick();
            post_busy = bus.o_busy;
            post_rd   = bus.o_rd;
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_cfg_we = 1'b0; bus.i_cfg_addr = 4'd0;
        bus.i_cfg_data = 8'd0; bus.i_win_valid = 1'b0; bus.i_pixel = '0;
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.o_busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        n_cmp++; if (bus.o_rd !== 1'b0)        begin n_bad++; $display("FAIL reset_rd: got %b want 0", bus.o_rd); end
        n_cmp++; if (bus.o_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.o_out_valid); end
        n_cmp++; if (bus.o_done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        n_cmp++; if (bus.o_pixelw !== 8'd0)    begin n_bad++; $display("FAIL reset_pixelw: got %0d want 0", bus.o_pixelw); end
        rst_n = 1'b1;
        set_identity();
        tick();
        clear_obs();
        bus.i_win_valid = 1'b1;
        drive_window(0);
        repeat (4) tick();
        bus.i_win_valid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (obs_pix.size() != 0) begin n_bad++; $display("FAIL idle_win_ignored: got %0d outputs want 0", obs_pix.size()); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_identity_frame();
        int first_v, last_c;
        run_frame(1, 0, 1'b0, 0);
        first_v = (obs_pix.size() > 0) ? obs_pix[0] : -1;
        last_c  = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : -1;
        n_cmp++; if (first_v != 37) begin n_bad++; $display("FAIL centre_37: got %0d want 37", first_v); end
        n_cmp++; if (rd_cnt != NPIX) begin n_bad++; $display("FAIL rd_count: got %0d want %0d", rd_cnt, NPIX); end
        n_cmp++; if (rd_last - rd_first + 1 != NPIX) begin n_bad++; $display("FAIL rd_span: got %0d want %0d", rd_last - rd_first + 1, NPIX); end
        n_cmp++; if (obs_pix.size() != NPIX) begin n_bad++; $display("FAIL out_count: got %0d want %0d", obs_pix.size(), NPIX); end
        for (int i = 0; i < exp_pix.size(); i++) begin
            int ov = (i < obs_pix.size()) ? obs_pix[i] : -1;
            int oc = (i < obs_cyc.size()) ? obs_cyc[i] : -1;
            n_cmp++;
            if (ov != exp_pix[i] || oc != exp_cyc[i]) begin
                n_bad++;
                $display("FAIL identity_pix[%0d]: got %0d at cycle %0d want %0d at cycle %0d", i, ov, oc, exp_pix[i], exp_cyc[i]);
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
        n_cmp++; if (done_cyc != last_c + 1) begin n_bad++; $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_c + 1); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done: got %b want 0", post_busy); end
        n_cmp++; if (post_rd !== 1'b0) begin n_bad++; $display("FAIL rd_after_done: got %b want 0", post_rd); end
    endtask

    task automatic test_saturation();
        int first_v;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 9; i++) write_coef(i, (f == 0) ? 16 : ((i == 4) ? -16 : 0));
            write_coef(12, 127);
            run_frame((f == 0) ? 2 : 3, 0, 1'b0, 0);
            first_v = (obs_pix.size() > 0) ? obs_pix[0] : -1;
            n_cmp++; if (first_v != ((f == 0) ? 255 : 0)) begin n_bad++; $display("FAIL sat_first_f%0d: got %0d want %0d", f, first_v, (f == 0) ? 255 : 0); end
            n_cmp++; if (obs_pix.size() != NPIX) begin n_bad++; $display("FAIL sat_count_f%0d: got %0d want %0d", f, obs_pix.size(), NPIX); end
            for (int i = 0; i < exp_pix.size(); i++) begin
                int ov = (i < obs_pix.size()) ? obs_pix[i] : -1;
                n_cmp++;
                if (ov != exp_pix[i]) begin
                    n_bad++;
                    $display("FAIL sat_pix_f%0d[%0d]: got %0d want %0d", f, i, ov, exp_pix[i]);
                end
            end
            n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL sat_done_f%0d: got %0d want 1", f, done_cnt); end
        end
    endtask

    task automatic test_run_ignores();
        for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? 16 : int'($urandom_range(0, 255)) - 128);
        run_frame(0, 3, 1'b1, 0);
        n_cmp++; if (rd_cnt != NPIX) begin n_bad++; $display("FAIL inject_rd_count: got %0d want %0d", rd_cnt, NPIX); end
        n_cmp++; if (obs_pix.size() != NPIX) begin n_bad++; $display("FAIL inject_out_count: got %0d want %0d", obs_pix.size(), NPIX); end
        for (int i = 0; i < exp_pix.size(); i++) begin
            int ov = (i < obs_pix.size()) ? obs_pix[i] : -1;
            int oc = (i < obs_cyc.size()) ? obs_cyc[i] : -1;
            n_cmp++;
            if (ov != exp_pix[i] || oc != exp_cyc[i]) begin
                n_bad++;
                $display("FAIL inject_pix[%0d]: got %0d at cycle %0d want %0d at cycle %0d", i, ov, oc, exp_pix[i], exp_cyc[i]);
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL inject_done: got %0d want 1", done_cnt); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL inject_busy_after: got %b want 0", post_busy); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(0, 0, 1'b0, 1000);
        n_cmp++; if (ab_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", ab_busy); end
        n_cmp++; if (ab_ov !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid: got %b want 0", ab_ov); end
        n_cmp++; if (ab_rd !== 1'b0) begin n_bad++; $display("FAIL abort_rd: got %b want 0", ab_rd); end
        n_cmp++; if (obs_pix.size() != 1000) begin n_bad++; $display("FAIL abort_out_count: got %0d want 1000", obs_pix.size()); end
        n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        for (int i = 0; i < 1000 && i < obs_pix.size(); i++) begin
            n_cmp++;
            if (obs_pix[i] != exp_pix[i]) begin
                n_bad++;
                $display("FAIL abort_pix[%0d]: got %0d want %0d", i, obs_pix[i], exp_pix[i]);
            end
        end
        set_identity();
        run_frame(0, 0, 1'b0, 0);
        n_cmp++; if (rd_cnt != NPIX) begin n_bad++; $display("FAIL clean_rd_count: got %0d want %0d", rd_cnt, NPIX); end
        n_cmp++; if (obs_pix.size() != NPIX) begin n_bad++; $display("FAIL clean_out_count: got %0d want %0d", obs_pix.size(), NPIX); end
        for (int i = 0; i < exp_pix.size(); i++) begin
            int ov = (i < obs_pix.size()) ? obs_pix[i] : -1;
            n_cmp++;
            if (ov != exp_pix[i]) begin
                n_bad++;
                $display("FAIL clean_pix[%0d]: got %0d want %0d", i, ov, exp_pix[i]);
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clean_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_identity_frame();
        test_saturation();
        test_run_ignores();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
